// File: rtl/trap_controller.sv
// trap_controller: arbitrates exceptions against level interrupts and sequences the CSR context switch.
// Optional macro TRAP_DELEG_EN: delegate traps to S-mode through MEDELEG / MIDELEG.
module trap_controller #(
  parameter int NUM_IRQ = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_IRQ-1:0] IRQ_IN,
  input  logic [NUM_IRQ-1:0] IRQ_EN,
  input  logic               GIE_M,
  input  logic               GIE_S,
  input  logic [1:0]         CUR_PRIV,
  input  logic               EXC_VALID,
  input  logic [4:0]         EXC_CODE,
  input  logic [63:0]        EXC_PC,
  input  logic [63:0]        INT_PC,
  input  logic [31:0]        MEDELEG,
  input  logic [NUM_IRQ-1:0] MIDELEG,
  input  logic               FLUSH_ACK,
  output logic               FLUSH_REQ,
  output logic               CS,
  output logic [1:0]         NEW_PRIVILEGE,
  output logic [63:0]        CAUSE,
  output logic [63:0]        NPC,
  output logic               REDIRECT,
  output logic               BUSY
);

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FLUSH  = 2'b01,
    SWITCH = 2'b10,
    VECTOR = 2'b11
  } state_t;

  state_t state_r;

  logic [1:0]         exc_priv_s;
  logic [NUM_IRQ-1:0] irq_deleg_s;
  logic [NUM_IRQ-1:0] irq_cand_s;
  logic               irq_found_s;
  logic [5:0]         irq_idx_s;
  logic [1:0]         irq_priv_s;
  logic               trap_s;
  logic [63:0]        trap_cause_s;
  logic [63:0]        trap_npc_s;
  logic [1:0]         trap_priv_s;

  // An interrupt aimed at a privilege level is only takeable when that level accepts it now.
  function automatic logic target_enabled(input logic [1:0] target, input logic [1:0] priv,
                                          input logic gie_m, input logic gie_s);
    logic en;
    if (target == PRIV_M) begin
      en = (priv != PRIV_M) || gie_m;
    end else if (target == PRIV_S) begin
      en = (priv == PRIV_U) || ((priv == PRIV_S) && gie_s);
    end else begin
      en = 1'b0;
    end
    return en;
  endfunction

`ifdef TRAP_DELEG_EN
  // Delegation to S never applies while running in M.
  always_comb begin
    if ((CUR_PRIV != PRIV_M) && MEDELEG[EXC_CODE]) begin
      exc_priv_s = PRIV_S;
    end else begin
      exc_priv_s = PRIV_M;
    end
    if (CUR_PRIV != PRIV_M) begin
      irq_deleg_s = MIDELEG;
    end else begin
      irq_deleg_s = {NUM_IRQ{1'b0}};
    end
  end
`else
  logic unused_deleg_s;
  assign unused_deleg_s = ^{MEDELEG, MIDELEG};

  // Without delegation every trap targets M.
  always_comb begin
    exc_priv_s  = PRIV_M;
    irq_deleg_s = {NUM_IRQ{1'b0}};
  end
`endif

  // Candidate lines, then highest index wins (later iterations override earlier ones).
  always_comb begin
    irq_found_s = 1'b0;
    irq_idx_s   = 6'd0;
    irq_priv_s  = PRIV_M;
    for (int i = 0; i < NUM_IRQ; i++) begin
      irq_cand_s[i] = IRQ_IN[i] && IRQ_EN[i] &&
                      target_enabled(irq_deleg_s[i] ? PRIV_S : PRIV_M, CUR_PRIV, GIE_M, GIE_S);
      irq_found_s   = irq_found_s | irq_cand_s[i];
      irq_idx_s     = irq_cand_s[i] ? 6'(i) : irq_idx_s;
      irq_priv_s    = irq_cand_s[i] ? (irq_deleg_s[i] ? PRIV_S : PRIV_M) : irq_priv_s;
    end
  end

  // Exception beats interrupt; the losing interrupt simply stays pending on its level.
  always_comb begin
    if (EXC_VALID) begin
      trap_s       = 1'b1;
      trap_cause_s = {1'b0, 58'd0, EXC_CODE};
      trap_npc_s   = EXC_PC;
      trap_priv_s  = exc_priv_s;
    end else if (irq_found_s) begin
      trap_s       = 1'b1;
      trap_cause_s = {1'b1, 57'd0, irq_idx_s};
      trap_npc_s   = INT_PC;
      trap_priv_s  = irq_priv_s;
    end else begin
      trap_s       = 1'b0;
      trap_cause_s = 64'd0;
      trap_npc_s   = 64'd0;
      trap_priv_s  = PRIV_M;
    end
  end

  // Trap sequencer with registered outputs; CAUSE/NPC/NEW_PRIVILEGE hold from accept to the next trap.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r       <= IDLE;
      FLUSH_REQ     <= 1'b0;
      CS            <= 1'b0;
      NEW_PRIVILEGE <= PRIV_M;
      CAUSE         <= 64'd0;
      NPC           <= 64'd0;
      REDIRECT      <= 1'b0;
      BUSY          <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (trap_s) begin
            state_r       <= FLUSH;
            FLUSH_REQ     <= 1'b1;
            BUSY          <= 1'b1;
            CAUSE         <= trap_cause_s;
            NPC           <= trap_npc_s;
            NEW_PRIVILEGE <= trap_priv_s;
          end else begin
            state_r <= IDLE;
          end
        end
        FLUSH: begin
          if (FLUSH_ACK) begin
            state_r   <= SWITCH;
            FLUSH_REQ <= 1'b0;
            CS        <= 1'b1;
          end else begin
            state_r <= FLUSH;
          end
        end
        SWITCH: begin
          state_r  <= VECTOR;
          CS       <= 1'b0;
          REDIRECT <= 1'b1;
        end
        VECTOR: begin
          state_r  <= IDLE;
          REDIRECT <= 1'b0;
          BUSY     <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          FLUSH_REQ <= 1'b0;
          CS        <= 1'b0;
          REDIRECT  <= 1'b0;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

endmodule
